// File: rtl/cpr_rr_buffer_if.sv
// Bus bundle for cpr_rr_buffer: write/read strobes, packed channel inputs and status.
// The master drives the strobes and data; the slave (the buffer) drives read data and status.
interface cpr_rr_buffer_if #(
    parameter int WIDTH = 16,
    parameter int NCH   = 2,
    parameter int DEPTH = 4
);
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);

    logic                   clr;
    logic                   we;
    logic                   re;
    logic [NCH*WIDTH-1:0]   wd;
    logic [WIDTH-1:0]       rd;
    logic                   rd_valid;
    logic [SELW-1:0]        sel;
    logic [CW-1:0]          count;
    logic                   full;
    logic                   empty;
    logic                   ovf;

    modport master (
        output clr, we, re, wd,
        input  rd, rd_valid, sel, count, full, empty, ovf
    );

    modport slave (
        input  clr, we, re, wd,
        output rd, rd_valid, sel, count, full, empty, ovf
    );
endinterface

// File: rtl/cpr_rr_buffer.sv
// Round-robin channel capture into a DEPTH-entry circular buffer with a registered,
// in-order read port. Channel selection advances only on accepted writes.
module cpr_rr_buffer #(
    parameter int WIDTH = 16,
    parameter int NCH   = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    cpr_rr_buffer_if.slave   bus
);
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdData_q, rdData_d;
    logic             rdValid_q, rdValid_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;

    logic             isFull;
    logic             isEmpty;
    logic             wrAcc;
    logic             rdAcc;
    logic [WIDTH-1:0] chanData;

    assign isFull  = (count_q == CW'(DEPTH));
    assign isEmpty = (count_q == '0);

    // A full buffer still accepts a write when a pop frees the slot on the same edge.
    assign wrAcc = !bus.clr && bus.we && (!isFull || bus.re);
    assign rdAcc = !bus.clr && bus.re && !isEmpty;

    always_comb begin
        chanData = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel_q == SELW'(k)) begin
                chanData = bus.wd[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        rdData_d  = rdData_q;
        rdValid_d = 1'b0;
        sel_d     = sel_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;

        if (bus.clr) begin
            sel_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            wrPtr_d = '0;
            rdPtr_d = '0;
        end else begin
            if (wrAcc) begin
                wrPtr_d = wrPtr_q + PW'(1);
                sel_d   = (sel_q == SELW'(NCH - 1)) ? '0 : sel_q + SELW'(1);
            end else if (bus.we) begin
                ovf_d = 1'b1;
            end

            if (rdAcc) begin
                rdData_d  = mem_q[rdPtr_q];
                rdValid_d = 1'b1;
                rdPtr_d   = rdPtr_q + PW'(1);
            end

            case ({wrAcc, rdAcc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
            sel_q     <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
        end else begin
            rdData_q  <= rdData_d;
            rdValid_q <= rdValid_d;
            sel_q     <= sel_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
        end
    end

    // Entries survive clr; only reset wipes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wrAcc) begin
            mem_q[wrPtr_q] <= chanData;
        end
    end

    assign bus.rd       = rdData_q;
    assign bus.rd_valid = rdValid_q;
    assign bus.sel      = sel_q;
    assign bus.count    = count_q;
    assign bus.full     = isFull;
    assign bus.empty    = isEmpty;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_cpr_rr_buffer.sv
// Directed bench for cpr_rr_buffer (WIDTH=16, NCH=2, DEPTH=4) with immediate assertions
// at each check point and hand-computed expectations.
module tb_cpr_rr_buffer;
    logic clk;
    logic rst_n;
    int   assertCount = 0;
    int   failCount   = 0;

    cpr_rr_buffer_if #(.WIDTH(16), .NCH(2), .DEPTH(4)) intf ();

    cpr_rr_buffer #(.WIDTH(16), .NCH(2), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of strobes, let the edge happen, then return to idle 1 time unit later.
    task automatic applyStimulus(input logic we, input logic re, input logic clr);
        intf.we  = we;
        intf.re  = re;
        intf.clr = clr;
        @(posedge clk);
        #1;
        intf.we  = 1'b0;
        intf.re  = 1'b0;
        intf.clr = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // full/empty expectations follow directly from the expected occupancy.
    task automatic checkState(input string tag, input logic [15:0] expRd, input logic expValid,
                              input int expCount, input logic expSel, input logic expOvf);
        checkOutput({tag, ".rd"},       32'(intf.rd),       32'(expRd));
        checkOutput({tag, ".rd_valid"}, 32'(intf.rd_valid), 32'(expValid));
        checkOutput({tag, ".count"},    32'(intf.count),    32'(expCount));
        checkOutput({tag, ".sel"},      32'(intf.sel),      32'(expSel));
        checkOutput({tag, ".ovf"},      32'(intf.ovf),      32'(expOvf));
        checkOutput({tag, ".full"},     32'(intf.full),     32'(expCount == 4));
        checkOutput({tag, ".empty"},    32'(intf.empty),    32'(expCount == 0));
    endtask

    initial begin
        logic [15:0] expData;
        logic [15:0] prevRd;

        rst_n    = 1'b0;
        intf.we  = 1'b0;
        intf.re  = 1'b0;
        intf.clr = 1'b0;
        intf.wd  = {16'h2222, 16'h1111};
        @(posedge clk);
        #1;
        checkState("reset", 16'h0000, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Round-robin capture then drain
        applyStimulus(1, 0, 0); checkState("t1w1",  16'h0000, 0, 1, 1, 0);
        applyStimulus(1, 0, 0); checkState("t1w2",  16'h0000, 0, 2, 0, 0);
        applyStimulus(1, 0, 0); checkState("t1w3",  16'h0000, 0, 3, 1, 0);
        applyStimulus(0, 1, 0); checkState("t1r1",  16'h1111, 1, 2, 1, 0);
        applyStimulus(0, 1, 0); checkState("t1r2",  16'h2222, 1, 1, 1, 0);
        applyStimulus(0, 1, 0); checkState("t1r3",  16'h1111, 1, 0, 1, 0);
        applyStimulus(0, 0, 0); checkState("t1idle", 16'h1111, 0, 0, 1, 0);

        // Overflow: fifth write dropped
        applyStimulus(0, 0, 1); checkState("t2clr", 16'h1111, 0, 0, 0, 0);
        applyStimulus(1, 0, 0); checkState("t2w1",  16'h1111, 0, 1, 1, 0);
        applyStimulus(1, 0, 0); checkState("t2w2",  16'h1111, 0, 2, 0, 0);
        applyStimulus(1, 0, 0); checkState("t2w3",  16'h1111, 0, 3, 1, 0);
        applyStimulus(1, 0, 0); checkState("t2w4",  16'h1111, 0, 4, 0, 0);
        applyStimulus(1, 0, 0); checkState("t2w5",  16'h1111, 0, 4, 0, 1);
        applyStimulus(0, 1, 0); checkState("t2r1",  16'h1111, 1, 3, 0, 1);
        applyStimulus(0, 1, 0); checkState("t2r2",  16'h2222, 1, 2, 0, 1);
        applyStimulus(0, 1, 0); checkState("t2r3",  16'h1111, 1, 1, 0, 1);
        applyStimulus(0, 1, 0); checkState("t2r4",  16'h2222, 1, 0, 0, 1);

        // Simultaneous write and read while full
        applyStimulus(0, 0, 1); checkState("t3clr", 16'h2222, 0, 0, 0, 0);
        applyStimulus(1, 0, 0); checkState("t3w1",  16'h2222, 0, 1, 1, 0);
        applyStimulus(1, 0, 0); checkState("t3w2",  16'h2222, 0, 2, 0, 0);
        applyStimulus(1, 0, 0); checkState("t3w3",  16'h2222, 0, 3, 1, 0);
        applyStimulus(1, 0, 0); checkState("t3w4",  16'h2222, 0, 4, 0, 0);
        intf.wd = {16'h2222, 16'hAAAA};
        applyStimulus(1, 1, 0); checkState("t3wr",  16'h1111, 1, 4, 1, 0);
        intf.wd = {16'h2222, 16'h1111};
        applyStimulus(0, 1, 0); checkState("t3r1",  16'h2222, 1, 3, 1, 0);
        applyStimulus(0, 1, 0); checkState("t3r2",  16'h1111, 1, 2, 1, 0);
        applyStimulus(0, 1, 0); checkState("t3r3",  16'h2222, 1, 1, 1, 0);
        applyStimulus(0, 1, 0); checkState("t3r4",  16'hAAAA, 1, 0, 1, 0);

        // Empty read is a no-op; we&re while empty writes only
        applyStimulus(0, 1, 0); checkState("t4re",  16'hAAAA, 0, 0, 1, 0);
        applyStimulus(1, 1, 0); checkState("t4wr",  16'hAAAA, 0, 1, 0, 0);
        applyStimulus(0, 1, 0); checkState("t4r",   16'h2222, 1, 0, 0, 0);

        // Wrap-around: pointers pass the end of the buffer twice
        prevRd = 16'h2222;
        for (int i = 0; i < 10; i++) begin
            intf.wd = {16'h2000 + 16'(i), 16'h1000 + 16'(i)};
            expData = (i % 2 == 1) ? 16'h2000 + 16'(i) : 16'h1000 + 16'(i);
            applyStimulus(1, 0, 0);
            checkState("t5w", prevRd, 0, 1, 1'((i + 1) % 2), 0);
            applyStimulus(0, 1, 0);
            checkState("t5r", expData, 1, 0, 1'((i + 1) % 2), 0);
            prevRd = expData;
        end

        // clr and async reset in the middle of operation
        intf.wd = {16'h2222, 16'h1111};
        applyStimulus(1, 0, 0); checkState("t6w1",  16'h2009, 0, 1, 1, 0);
        applyStimulus(1, 0, 0); checkState("t6w2",  16'h2009, 0, 2, 0, 0);
        applyStimulus(1, 0, 0); checkState("t6w3",  16'h2009, 0, 3, 1, 0);
        applyStimulus(1, 0, 0); checkState("t6w4",  16'h2009, 0, 4, 0, 0);
        applyStimulus(1, 0, 0); checkState("t6w5",  16'h2009, 0, 4, 0, 1);
        applyStimulus(0, 1, 0); checkState("t6r1",  16'h1111, 1, 3, 0, 1);
        applyStimulus(1, 1, 1); checkState("t6clr", 16'h1111, 0, 0, 0, 0);
        applyStimulus(1, 0, 0); checkState("t6w6",  16'h1111, 0, 1, 1, 0);
        applyStimulus(1, 0, 0); checkState("t6w7",  16'h1111, 0, 2, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        checkState("t6rst", 16'h0000, 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        applyStimulus(0, 1, 0); checkState("t6re",  16'h0000, 0, 0, 0, 0);
        applyStimulus(1, 0, 0); checkState("t6w8",  16'h0000, 0, 1, 1, 0);
        applyStimulus(0, 1, 0); checkState("t6r2",  16'h1111, 1, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
